// File: rtl/bcd_seg7_scan_if.sv
// Bus between the BCD converter side and the seven-segment scanner.
// The master drives the capture strobe and data; the slave drives the display pins.
interface bcd_seg7_scan_if #(
   parameter int N_DIG = 8
) ();
   logic                 load;
   logic [4*N_DIG-1:0]   dig_in;
   logic [N_DIG-1:0]     dp_in;
   logic [N_DIG-1:0]     an;
   logic [6:0]           seg;
   logic                 dp;
   logic                 frame_tick;

   modport master (
      output load, dig_in, dp_in,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  load, dig_in, dp_in,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed seven-segment scanner: captures BCD digits on load, commits them only
// at frame boundaries, blanks leading zeros. The first frame after reset is shown dark.
module bcd_seg7_scan #(
   parameter int N_DIG       = 8,
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   bcd_seg7_scan_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(N_DIG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
   localparam logic POL = ACTIVE_LOW;

   typedef enum logic {
      CAP_IDLE,
      CAP_PENDING
   } cap_state_t;

   cap_state_t cap_state, cap_state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic               slot_end;
   logic               wrap;
   logic               commit;
   logic               started;

   logic [4*N_DIG-1:0] shadow;
   logic [N_DIG-1:0]   shadow_dp;
   logic [4*N_DIG-1:0] active;
   logic [N_DIG-1:0]   active_dp;

   logic [N_DIG-1:0]   upper_zero;
   logic [3:0]         cur_dig;
   logic               cur_dp;
   logic               cur_upper;
   logic               blank;

   logic [N_DIG-1:0]   an_on;
   logic [6:0]         seg_on;
   logic               dp_on;

   logic [N_DIG-1:0]   an_q;
   logic [6:0]         seg_q;
   logic               dp_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   assign slot_end = (cnt == CNT_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_state <= CAP_IDLE;
      end else begin
         cap_state <= cap_state_nxt;
      end
   end

   // A load on the boundary cycle wins over the commit, deferring it by one frame.
   always_comb begin
      cap_state_nxt = cap_state;
      commit        = 1'b0;
      case (cap_state)
         CAP_IDLE: begin
            if (bus.load) begin
               cap_state_nxt = CAP_PENDING;
            end
         end
         CAP_PENDING: begin
            if (!bus.load && wrap) begin
               commit        = 1'b1;
               cap_state_nxt = CAP_IDLE;
            end
         end
         default: begin
            cap_state_nxt = CAP_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow    <= '0;
         shadow_dp <= '0;
         active    <= '0;
         active_dp <= '0;
         started   <= 1'b0;
      end else begin
         if (bus.load) begin
            shadow    <= bus.dig_in;
            shadow_dp <= bus.dp_in;
         end
         if (commit) begin
            active    <= shadow;
            active_dp <= shadow_dp;
         end
         if (wrap) begin
            started <= 1'b1;
         end
      end
   end

   always_comb begin : lz_scan
      logic run;
      run        = 1'b1;
      upper_zero = '0;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         run           = run & (active[4*i +: 4] == 4'd0);
         upper_zero[i] = run;
      end
   end

   always_comb begin
      cur_dig   = '0;
      cur_dp    = 1'b0;
      cur_upper = 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_dig   = active[4*i +: 4];
            cur_dp    = active_dp[i];
            cur_upper = upper_zero[i];
         end
      end
   end

   assign blank = BLANK_LZ && (idx != '0) && cur_upper;

   // A blanked digit keeps its anode on only so that its decimal point can still light.
   always_comb begin
      an_on  = '0;
      seg_on = '0;
      dp_on  = 1'b0;
      if (started) begin
         for (int i = 0; i < N_DIG; i++) begin
            if ((idx == IDX_W'(i)) && (!blank || cur_dp)) begin
               an_on[i] = 1'b1;
            end
         end
         if (!blank) begin
            seg_on = seg_decode(cur_dig);
         end
         dp_on = cur_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= {N_DIG{POL}};
         seg_q <= {7{POL}};
         dp_q  <= POL;
      end else begin
         an_q  <= an_on ^ {N_DIG{POL}};
         seg_q <= seg_on ^ {7{POL}};
         dp_q  <= dp_on ^ POL;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = wrap;

endmodule
